// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector family.
// Holds the default sizing, output-mode constants and the length-to-mask helper.
package seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int LEN_W       = $clog2(DEF_MAX_LEN + 1);

    localparam bit MODE_MEALY = 1'b0;
    localparam bit MODE_MOORE = 1'b1;

    // Patterns are right-aligned, so only the low len bits take part in a compare.
    function automatic logic [31:0] mask_len(input int unsigned len);
        if (len >= 32) begin
            return '1;
        end
        return (32'd1 << len) - 32'd1;
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter: advances once per inc pulse and sticks at all-ones.
// sat is high for as long as the count holds its maximum value.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign sat = &cnt_q;
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Run-time loadable serial bit-pattern detector with optional overlap and
// Moore/Mealy output, input qualification and a saturating match counter.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(3'b011),
    parameter int                 DEF_LEN = 3,
    parameter bit                 OVERLAP = 1'b1,
    parameter bit                 MOORE   = MODE_MOORE,
    parameter int                 CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         x,
    input  logic                         x_vld,
    input  logic                         load,
    input  logic [MAX_LEN-1:0]           pat_in,
    input  logic [$clog2(MAX_LEN+1)-1:0] len_in,
    output logic                         y,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         cnt_sat,
    output logic                         len_err
);

    localparam int LW = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] pat_q,  pat_d;
    logic [LW-1:0]      len_q,  len_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic               len_err_q, len_err_d;
    logic               y_q, y_d;

    logic               accept;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] pat_mask;
    logic               fill_ok;
    logic               pat_eq;
    logic               hit;

    // The incoming bit is compared together with the stored history, so a
    // match is recognised in the same cycle its final bit is sampled.
    always_comb begin
        accept   = x_vld && !load && !rst;
        window   = {hist_q[MAX_LEN-2:0], x};
        pat_mask = MAX_LEN'(mask_len(32'(len_q)));
        fill_ok  = ({1'b0, fill_q} + (LW+1)'(1)) >= {1'b0, len_q};
        pat_eq   = ((window ^ pat_q) & pat_mask) == '0;
        hit      = accept && !len_err_q && fill_ok && pat_eq;
    end

    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        len_err_d = len_err_q;
        y_d       = hit;
        if (load) begin
            pat_d     = pat_in;
            len_d     = len_in;
            hist_d    = '0;
            fill_d    = '0;
            len_err_d = (len_in < LW'(2)) || (32'(len_in) > MAX_LEN);
        end else if (x_vld) begin
            hist_d = window;
            if (fill_q != LW'(MAX_LEN)) begin
                fill_d = fill_q + LW'(1);
            end
            // Non-overlapping mode forgets everything that formed the match.
            if (hit && !OVERLAP) begin
                fill_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q     <= DEF_PAT;
            len_q     <= LW'(DEF_LEN);
            hist_q    <= '0;
            fill_q    <= '0;
            len_err_q <= 1'b0;
            y_q       <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            len_q     <= len_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            len_err_q <= len_err_d;
            y_q       <= y_d;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_match_counter (
        .clk(clk),
        .rst(rst),
        .inc(hit),
        .cnt(match_cnt),
        .sat(cnt_sat)
    );

    assign y       = (MOORE == MODE_MOORE) ? y_q : hit;
    assign len_err = len_err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: three instances (Moore/overlap,
// Moore/non-overlap, Mealy/overlap with a 3-bit counter) share one stimulus stream.
module tb_seq_detect_param;

    localparam int LW = seq_det_pkg::LEN_W;
    localparam logic [2:0] IS_MOORE = 3'b011;

    logic          clk = 1'b0;
    logic          rst;
    logic          x;
    logic          x_vld;
    logic          load;
    logic [7:0]    pat_in;
    logic [LW-1:0] len_in;

    logic       y_a, y_b, y_c;
    logic [7:0] cnt_a, cnt_b;
    logic [2:0] cnt_c;
    logic       sat_a, sat_b, sat_c;
    logic       err_a, err_b, err_c;

    int checks = 0;
    int errors = 0;
    int unsigned acc_idx = 0;
    int unsigned exp_q [3][$];

    always #5 clk = ~clk;

    seq_detect_param #(
        .OVERLAP(1'b1), .MOORE(seq_det_pkg::MODE_MOORE), .CNT_W(8)
    ) dut_a (
        .clk(clk), .rst(rst), .x(x), .x_vld(x_vld), .load(load),
        .pat_in(pat_in), .len_in(len_in),
        .y(y_a), .match_cnt(cnt_a), .cnt_sat(sat_a), .len_err(err_a)
    );

    seq_detect_param #(
        .OVERLAP(1'b0), .MOORE(seq_det_pkg::MODE_MOORE), .CNT_W(8)
    ) dut_b (
        .clk(clk), .rst(rst), .x(x), .x_vld(x_vld), .load(load),
        .pat_in(pat_in), .len_in(len_in),
        .y(y_b), .match_cnt(cnt_b), .cnt_sat(sat_b), .len_err(err_b)
    );

    seq_detect_param #(
        .OVERLAP(1'b1), .MOORE(seq_det_pkg::MODE_MEALY), .CNT_W(3)
    ) dut_c (
        .clk(clk), .rst(rst), .x(x), .x_vld(x_vld), .load(load),
        .pat_in(pat_in), .len_in(len_in),
        .y(y_c), .match_cnt(cnt_c), .cnt_sat(sat_c), .len_err(err_c)
    );

    // Drive one cycle of inputs; expected hits are queued by accepted-bit index.
    task automatic applyStimulus(input logic r, input logic ld, input logic vld,
                                 input logic xb, input logic [7:0] p,
                                 input logic [LW-1:0] l, input logic [2:0] hits);
        @(negedge clk);
        rst    = r;
        load   = ld;
        x_vld  = vld;
        x      = xb;
        pat_in = p;
        len_in = l;
        if (!r && !ld && vld) begin
            acc_idx++;
            for (int d = 0; d < 3; d++) begin
                if (hits[d]) exp_q[d].push_back(acc_idx);
            end
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Bits and hit masks are given MSB-first: the leftmost bit is sent first.
    task automatic feedBits(input logic [15:0] bits, input int n,
                            input logic [15:0] ha, input logic [15:0] hb,
                            input logic [15:0] hc);
        for (int i = 0; i < n; i++) begin
            int k;
            k = n - 1 - i;
            applyStimulus(1'b0, 1'b0, 1'b1, bits[k], 8'h00, '0, {hc[k], hb[k], ha[k]});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, '0, 3'b000);
        end
    endtask

    // x is held high with x_vld during the load cycle; it must be ignored.
    task automatic doLoad(input logic [7:0] p, input logic [LW-1:0] l);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, p, l, 3'b000);
    endtask

    task automatic settle();
        @(negedge clk);
        rst   = 1'b0;
        load  = 1'b0;
        x_vld = 1'b0;
        x     = 1'b0;
        #1;
    endtask

    task automatic checkCounts(input string tag, input int ea, input int eb, input int ec,
                               input int sc);
        checkOutput({tag, "_cnt_a"}, int'(cnt_a), ea);
        checkOutput({tag, "_cnt_b"}, int'(cnt_b), eb);
        checkOutput({tag, "_cnt_c"}, int'(cnt_c), ec);
        checkOutput({tag, "_sat_c"}, int'(sat_c), sc);
    endtask

    // Monitor: samples between the input change and the next rising edge.
    // Moore pulses belong to the bit accepted in the previous cycle, Mealy to the current one.
    int unsigned mon_acc  = 0;
    int unsigned mon_prev = 0;
    always @(negedge clk) begin
        int unsigned cur;
        int unsigned tgt;
        int unsigned e;
        logic [2:0]  yv;
        #2;
        yv  = {y_c, y_b, y_a};
        cur = (!rst && x_vld && !load) ? mon_acc + 1 : 0;
        for (int d = 0; d < 3; d++) begin
            if (yv[d] === 1'b1) begin
                tgt = IS_MOORE[d] ? mon_prev : cur;
                checks++;
                if (exp_q[d].size() == 0) begin
                    errors++;
                    $display("[TB] FAIL y_pulse dut%0d: got pulse on bit %0d expected no pulse", d, tgt);
                end else begin
                    e = exp_q[d].pop_front();
                    if (e != tgt) begin
                        errors++;
                        $display("[TB] FAIL y_pulse dut%0d: got pulse on bit %0d expected bit %0d", d, tgt, e);
                    end
                end
            end
        end
        mon_prev = cur;
        if (cur != 0) mon_acc = cur;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; load = 1'b0; x_vld = 1'b0; x = 1'b0; pat_in = '0; len_in = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, '0, 3'b000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, '0, 3'b000);
        settle();
        checkCounts("reset", 0, 0, 0, 0);
        checkOutput("reset_sat_a", int'(sat_a), 0);
        checkOutput("reset_err_a", int'(err_a), 0);
        checkOutput("reset_y_a", int'(y_a), 0);

        $display("[TB] default pattern 011 stream");
        feedBits(16'b001101101, 9, 16'b000100100, 16'b000100100, 16'b000100100);
        settle();
        checkCounts("t1", 2, 2, 2, 0);

        $display("[TB] pattern 11, overlap vs non-overlap");
        doLoad(8'b0000_0011, LW'(2));
        feedBits(16'b1111, 4, 16'b0111, 16'b0101, 16'b0111);
        settle();
        checkCounts("t2", 5, 4, 5, 0);

        $display("[TB] x_vld gaps");
        doLoad(8'b0000_0011 + 8'd0 - 8'd0 == 8'h03 ? 8'b0000_0011 : 8'h00, LW'(3));
        feedBits(16'b0, 1, 16'b0, 16'b0, 16'b0);
        idle(3);
        feedBits(16'b1, 1, 16'b0, 16'b0, 16'b0);
        idle(3);
        feedBits(16'b1, 1, 16'b1, 16'b1, 16'b1);
        settle();
        checkCounts("t3", 6, 5, 6, 0);

        $display("[TB] length error then valid 8-bit load");
        doLoad(8'hFF, LW'(9));
        settle();
        checkOutput("t4_err_a", int'(err_a), 1);
        checkOutput("t4_err_c", int'(err_c), 1);
        feedBits(16'b011011, 6, 16'b0, 16'b0, 16'b0);
        feedBits(16'b1111, 4, 16'b0, 16'b0, 16'b0);
        settle();
        checkCounts("t4_frozen", 6, 5, 6, 0);
        doLoad(8'b1010_0110, LW'(8));
        settle();
        checkOutput("t4_err_b_clear", int'(err_b), 0);
        feedBits(16'b10100110, 8, 16'b00000001, 16'b00000001, 16'b00000001);
        settle();
        checkCounts("t4", 7, 6, 7, 1);
        checkOutput("t4_sat_a", int'(sat_a), 0);

        $display("[TB] reset mid-pattern, reset beats load");
        feedBits(16'b01, 2, 16'b0, 16'b0, 16'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'b0000_0011, LW'(2), 3'b000);
        settle();
        checkCounts("t5_rst", 0, 0, 0, 0);
        checkOutput("t5_err_a", int'(err_a), 0);
        feedBits(16'b11011, 5, 16'b00001, 16'b00001, 16'b00001);
        settle();
        checkCounts("t5", 1, 1, 1, 0);

        $display("[TB] counter saturation");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, '0, 3'b000);
        doLoad(8'b0000_0011, LW'(2));
        feedBits(16'b1111111, 7, 16'b0111111, 16'b0101010, 16'b0111111);
        settle();
        checkCounts("t6_pre", 6, 3, 6, 0);
        feedBits(16'b1, 1, 16'b1, 16'b1, 16'b1);
        settle();
        checkCounts("t6_sat", 7, 4, 7, 1);
        checkOutput("t6_sat_a", int'(sat_a), 0);
        feedBits(16'b11, 2, 16'b11, 16'b01, 16'b11);
        settle();
        checkCounts("t6_hold", 9, 5, 7, 1);

        idle(3);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("pending_pulses_dut%0d", d), exp_q[d].size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
